// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller
// Central sequencer for the 5-stage pipeline. Merges load-use stalls, taken
// branches, mul/div occupancy and data-memory wait into per-register write
// enables and bubble (flush) controls. Tracks mul/div occupancy with a
// down-counter and keeps a saturating count of PC-hold cycles.
//
// Ports:
//   Clock            in   system clock, rising edge
//   Reset            in   synchronous, active-high reset
//   HazardStall      in   load-use stall: hold PC/IFID, bubble IDEX
//   BranchTaken      in   taken branch/jump in ID: bubble IFID
//   MulDivStart      in   mul/div in EX, not yet started
//   MemBusy          in   data memory not ready, MEM must hold
//   *WriteEnable     out  per-register load enables (combinational)
//   *Flush           out  load a bubble instead of data (combinational)
//   MulDivBusy       out  high while waiting on mul/div
//   MulDivDone       out  one-cycle pulse on the mul/div release cycle
//   StallCycles      out  saturating count of cycles with PCWriteEnable = 0
module pipeline_stall_controller #(
    parameter int unsigned MULDIV_CYCLES = 4,
    parameter int unsigned STALL_CNT_W   = 16
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   HazardStall,
    input  logic                   BranchTaken,
    input  logic                   MulDivStart,
    input  logic                   MemBusy,
    output logic                   PCWriteEnable,
    output logic                   IFIDWriteEnable,
    output logic                   IDEXWriteEnable,
    output logic                   EXMEMWriteEnable,
    output logic                   MEMWBWriteEnable,
    output logic                   IFIDFlush,
    output logic                   IDEXFlush,
    output logic                   EXMEMFlush,
    output logic                   MEMWBFlush,
    output logic                   MulDivBusy,
    output logic                   MulDivDone,
    output logic [STALL_CNT_W-1:0] StallCycles
);

    localparam int unsigned COUNT_W = 8;

    typedef enum logic [0:0] {
        RUN         = 1'b0,
        MULDIV_WAIT = 1'b1
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic [COUNT_W-1:0]     count;
    logic [COUNT_W-1:0]     next_count;
    logic [STALL_CNT_W-1:0] stall_cycles;

    // State, occupancy counter and stall performance counter
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state        <= RUN;
            count        <= '0;
            stall_cycles <= '0;
        end else begin
            state <= next_state;
            count <= next_count;
            if (!PCWriteEnable && !(&stall_cycles)) begin
                stall_cycles <= stall_cycles + STALL_CNT_W'(1);
            end
        end
    end

    // Next-state and pipeline control decode
    always_comb begin
        next_state       = state;
        next_count       = count;
        PCWriteEnable    = 1'b1;
        IFIDWriteEnable  = 1'b1;
        IDEXWriteEnable  = 1'b1;
        EXMEMWriteEnable = 1'b1;
        MEMWBWriteEnable = 1'b1;
        IFIDFlush        = 1'b0;
        IDEXFlush        = 1'b0;
        EXMEMFlush       = 1'b0;
        MEMWBFlush       = 1'b0;
        MulDivDone       = 1'b0;
        MulDivBusy       = 1'b0;

        if (Reset) begin
            // Freeze every register and issue no bubbles while in reset
            PCWriteEnable    = 1'b0;
            IFIDWriteEnable  = 1'b0;
            IDEXWriteEnable  = 1'b0;
            EXMEMWriteEnable = 1'b0;
            MEMWBWriteEnable = 1'b0;
        end else begin
            MulDivBusy = (state == MULDIV_WAIT);
            if (MemBusy) begin
                // MEM holds; everything upstream holds, WB gets a bubble.
                // Count is left untouched so the release slides by one cycle.
                PCWriteEnable    = 1'b0;
                IFIDWriteEnable  = 1'b0;
                IDEXWriteEnable  = 1'b0;
                EXMEMWriteEnable = 1'b0;
                MEMWBFlush       = 1'b1;
            end else begin
                case (state)
                    RUN: begin
                        if (MulDivStart) begin
                            PCWriteEnable   = 1'b0;
                            IFIDWriteEnable = 1'b0;
                            IDEXWriteEnable = 1'b0;
                            EXMEMFlush      = 1'b1;
                            next_count      = COUNT_W'(MULDIV_CYCLES - 2);
                            next_state      = MULDIV_WAIT;
                        end else if (HazardStall) begin
                            PCWriteEnable   = 1'b0;
                            IFIDWriteEnable = 1'b0;
                            IDEXFlush       = 1'b1;
                        end else if (BranchTaken) begin
                            IFIDFlush = 1'b1;
                        end
                    end
                    MULDIV_WAIT: begin
                        if (count != '0) begin
                            PCWriteEnable   = 1'b0;
                            IFIDWriteEnable = 1'b0;
                            IDEXWriteEnable = 1'b0;
                            EXMEMFlush      = 1'b1;
                            next_count      = count - COUNT_W'(1);
                        end else begin
                            // Release: EX result advances; ID requests apply now
                            MulDivDone = 1'b1;
                            next_state = RUN;
                            if (HazardStall) begin
                                PCWriteEnable   = 1'b0;
                                IFIDWriteEnable = 1'b0;
                                IDEXFlush       = 1'b1;
                            end else if (BranchTaken) begin
                                IFIDFlush = 1'b1;
                            end
                        end
                    end
                    default: begin
                        next_state = RUN;
                    end
                endcase
            end
        end
    end

    assign StallCycles = stall_cycles;

endmodule

// File: doc/pipeline_stall_controller.md
# pipeline_stall_controller

Central pipeline sequencer for the 5-stage MIPS core. It merges stall and flush requests from the hazard detection unit, the branch resolver in ID, the multi-cycle mul/div unit in EX and the data-memory wait line into one coherent set of per-stage write enables and bubble (flush) controls. It also tracks mul/div occupancy with a down-counter and keeps a saturating stall-cycle performance counter.

## Interface
- MULDIV_CYCLES, 4: total EX-stage occupancy of a mul/div instruction, in cycles, including its start cycle and its release cycle; legal range 2..255.
- STALL_CNT_W, 16: width of the stall performance counter.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- HazardStall  in  1  load-use stall request from hazard detection: hold PC/IFID and bubble IDEX.
- BranchTaken  in  1  branch/jump resolved taken in ID: flush IFID.
- MulDivStart  in  1  mul/div instruction present in EX and not yet started.
- MemBusy  in  1  data memory not ready; MEM stage must hold.
- PCWriteEnable, IFIDWriteEnable, IDEXWriteEnable, EXMEMWriteEnable, MEMWBWriteEnable  out  1 each  per-register load enables.
- IFIDFlush, IDEXFlush, EXMEMFlush, MEMWBFlush  out  1 each  load a bubble (NOP, control bits zero) instead of data.
- MulDivBusy  out  1  high while state is MULDIV_WAIT.
- MulDivDone  out  1  one-cycle pulse on the mul/div release cycle.
- StallCycles  out  STALL_CNT_W  count of cycles with PCWriteEnable = 0.

## Operation
- FSM states: RUN and MULDIV_WAIT. A down-counter Count is 8 bits wide.
- A flush is asserted only when the matching enable is 1. An enable of 0 means hold.
- Default outputs: all enables 1, all flushes 0, MulDivDone 0.
- RUN, first matching priority wins:
  1. MemBusy: PC, IFID, IDEX and EXMEM enables = 0; MEMWBFlush = 1. No state change. MulDivStart is not accepted; the instruction stays in EX and re-requests.
  2. MulDivStart: PC, IFID and IDEX enables = 0; EXMEMFlush = 1. Count <= MULDIV_CYCLES-2. Next state MULDIV_WAIT.
  3. HazardStall: PC and IFID enables = 0; IDEXFlush = 1.
  4. BranchTaken: IFIDFlush = 1.
  5. Otherwise: defaults.
- MULDIV_WAIT:
  - MemBusy: same outputs as RUN priority 1. Count is frozen.
  - Else if Count != 0: same hold as the MulDivStart cycle (PC/IFID/IDEX hold, EXMEMFlush = 1). Count decrements.
  - Else (release cycle): MulDivDone = 1; EX result advances into EXMEM. HazardStall and BranchTaken are evaluated per RUN priorities 3–5. Next state RUN.
  - MulDivStart is ignored in MULDIV_WAIT. HazardStall and BranchTaken are ignored on every non-release cycle; the ID instruction is held, so they re-assert.
- StallCycles increments each cycle PCWriteEnable = 0 and Reset = 0. It saturates at all-ones.

## Timing
- Outputs are combinational from state, Count and the current-cycle inputs; requests take effect in the same cycle.
- State, Count and StallCycles update on the rising edge of Clock.
- Reset = 1 forces, in that cycle, all enables 0, all flushes 0, MulDivBusy 0 and MulDivDone 0. At the next edge: state RUN, Count 0, StallCycles 0.
- Reset mid-mul/div aborts the operation. The first cycle after reset is RUN with default outputs (absent requests).
- Mul/div with no MemBusy: PC is held for exactly MULDIV_CYCLES-1 cycles; the release is MULDIV_CYCLES-1 cycles after the start.
- Each MemBusy cycle during MULDIV_WAIT extends the release by exactly one cycle.
- Simultaneous events:
  - MulDivStart with HazardStall or BranchTaken: mul/div wins.
  - HazardStall with BranchTaken: the stall wins; BranchTaken re-asserts the next cycle.
  - MemBusy beats everything.
- MULDIV_CYCLES = 2: the start cycle loads Count = 0; the next cycle is the release.

## Test plan
- Reset then idle, no requests → all enables 1, flushes 0, StallCycles = 0, MulDivBusy 0.
- HazardStall for 1 cycle → that cycle PC/IFID enables 0, IDEXFlush 1; next cycle defaults; StallCycles = 1.
- MULDIV_CYCLES = 4, MulDivStart at cycle 0 → PC held in cycles 0–2; EXMEMFlush 1 in cycles 0–2; MulDivBusy 1 in cycles 1–3; MulDivDone 1 only in cycle 3; StallCycles = 3.
- Same as above, plus MemBusy in cycle 2 → MEMWBFlush 1 in cycle 2; release moves to cycle 4; StallCycles = 4.
- HazardStall and BranchTaken together in cycle 0, BranchTaken alone in cycle 1 → cycle 0 IDEXFlush 1 and IFIDFlush 0; cycle 1 IFIDFlush 1 with all enables 1.
- Reset asserted in cycle 1 of a mul/div → cycle 2 is RUN, MulDivBusy 0, MulDivDone never pulses. A separate run with 70000 continuous stall cycles → StallCycles saturates at 0xFFFF.
